// File: rtl/thermo_scan_pkg.sv
// Shared types and helpers for the pipelined thermometer scanner.
// Imported by thermo_scan_stage and thermo_scan_pipe.
package thermo_scan_pkg;

  typedef enum logic {
    THERMO_FILL_DOWN = 1'b0,
    THERMO_FILL_UP   = 1'b1
  } thermo_mode_e;

  // Widest vector the reversal helper supports.
  localparam int THERMO_MAX_W = 256;

  // Prefix-OR levels per stage: ceil(clog2(width) / stages).
  function automatic int thermo_levels_per_stage(input int width, input int stages);
    int lvls;
    lvls = $clog2(width);
    return (lvls + stages - 1) / stages;
  endfunction

  // Reverses the low `width` bits of v. The whole THERMO_MAX_W vector is reversed,
  // then shifted down so the meaningful bits land at [width-1:0].
  function automatic logic [THERMO_MAX_W-1:0] bit_reverse(input logic [THERMO_MAX_W-1:0] v,
                                                          input int unsigned width);
    logic [THERMO_MAX_W-1:0] mask;
    logic [THERMO_MAX_W-1:0] rev;
    mask = (THERMO_MAX_W'(1) << width) - THERMO_MAX_W'(1);
    for (int i = 0; i < THERMO_MAX_W; i++) begin
      rev[i] = v[THERMO_MAX_W-1-i];
    end
    return (rev >> (THERMO_MAX_W - width)) & mask;
  endfunction

endpackage

// File: rtl/thermo_scan_stage.sv
// One registered stage of the scanner: prefix-OR levels [FIRST_LVL, LAST_LVL)
// followed by a bubble-collapsing valid/ready payload register.
module thermo_scan_stage
  import thermo_scan_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int FIRST_LVL = 0,
  parameter int LAST_LVL  = 1,
  parameter int TAG_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  thermo_mode_e     in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output thermo_mode_e     out_mode,
  output logic [TAG_W-1:0] out_tag
);

  logic [WIDTH-1:0] scan;
  logic             valid_q;
  logic [WIDTH-1:0] data_q;
  thermo_mode_e     mode_q;
  logic [TAG_W-1:0] tag_q;

  // Sklansky-style fill toward bit 0: at level l every bit in the lower half of a
  // 2^(l+1) block ORs in the lowest bit of the upper half. That boundary bit is not
  // modified at this level, so updating in place is safe.
  // NOTE: scan gets its full default before the loops, so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    scan = in_data;
    for (int l = FIRST_LVL; l < LAST_LVL; l++) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (((i >> l) & 1) == 0) begin
          scan[i] = scan[i] | scan[(i | (1 << l)) & ~((1 << l) - 1)];
        end
      end
    end
  end

  // Load when empty or when the current content leaves on this same edge.
  assign in_ready = !valid_q || out_ready;

  // NOTE: state registers use non-blocking assignments so every stage samples the
  // pre-edge value of its neighbour; blocking here would shoot data through stages.
  // NOTE: the payload is reset too, so out_data/out_tag read as zero out of reset
  // rather than whatever the flops powered up with.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      mode_q  <= THERMO_FILL_DOWN;
      tag_q   <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= scan;
        mode_q <= in_mode;
        tag_q  <= in_tag;
      end
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_mode  = mode_q;
  assign out_tag   = tag_q;

endmodule

// File: rtl/thermo_scan_pipe.sv
// Pipelined thermometer scanner: optional entry reversal, NUM_STAGES prefix-OR
// stages, exit reversal and leading-one index/count derived from the result.
module thermo_scan_pipe
  import thermo_scan_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int NUM_STAGES = 2,
  parameter int TAG_W      = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  input  logic                     in_mode,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic [$clog2(WIDTH):0]   out_count,
  output logic                     out_zero,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int LVLS = $clog2(WIDTH);
  localparam int LPS  = thermo_levels_per_stage(WIDTH, NUM_STAGES);
  localparam int IW   = LVLS;
  localparam int CW   = LVLS + 1;

  // Element k is the input of stage k; element NUM_STAGES is the pipe output.
  logic                 valid_s [NUM_STAGES+1];
  logic                 ready_s [NUM_STAGES+1];
  logic [WIDTH-1:0]     data_s  [NUM_STAGES+1];
  thermo_mode_e         mode_s  [NUM_STAGES+1];
  logic [TAG_W-1:0]     tag_s   [NUM_STAGES+1];

  thermo_mode_e     entry_mode;
  logic [WIDTH-1:0] entry_rev;
  logic [WIDTH-1:0] exit_rev;
  logic [WIDTH-1:0] thermo;
  logic [CW-1:0]    cnt;
  logic [IW-1:0]    idx;

  // FILL_UP is a FILL_DOWN scan on the mirrored vector; mode rides with the data.
  assign entry_mode = thermo_mode_e'(in_mode);
  assign entry_rev  = WIDTH'(bit_reverse(THERMO_MAX_W'(in_data), WIDTH));

  assign valid_s[0] = in_valid;
  assign data_s[0]  = (entry_mode == THERMO_FILL_UP) ? entry_rev : in_data;
  assign mode_s[0]  = entry_mode;
  assign tag_s[0]   = in_tag;
  assign in_ready   = ready_s[0];
  assign ready_s[NUM_STAGES] = out_ready;

  for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
    // Trailing stages may own no levels when LPS*NUM_STAGES overshoots LVLS.
    localparam int FL = (k * LPS < LVLS) ? k * LPS : LVLS;
    localparam int LL = ((k + 1) * LPS < LVLS) ? (k + 1) * LPS : LVLS;

    thermo_scan_stage #(
      .WIDTH     (WIDTH),
      .FIRST_LVL (FL),
      .LAST_LVL  (LL),
      .TAG_W     (TAG_W)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (valid_s[k]),
      .in_ready  (ready_s[k]),
      .in_data   (data_s[k]),
      .in_mode   (mode_s[k]),
      .in_tag    (tag_s[k]),
      .out_valid (valid_s[k+1]),
      .out_ready (ready_s[k+1]),
      .out_data  (data_s[k+1]),
      .out_mode  (mode_s[k+1]),
      .out_tag   (tag_s[k+1])
    );
  end

  assign exit_rev = WIDTH'(bit_reverse(THERMO_MAX_W'(data_s[NUM_STAGES]), WIDTH));
  assign thermo   = (mode_s[NUM_STAGES] == THERMO_FILL_UP) ? exit_rev : data_s[NUM_STAGES];

  // Index falls out of the popcount: down -> count-1, up -> WIDTH-count.
  always_comb begin
    cnt = CW'($countones(thermo));
    idx = '0;
    if (cnt != '0) begin
      if (mode_s[NUM_STAGES] == THERMO_FILL_UP) begin
        idx = IW'(CW'(WIDTH) - cnt);
      end else begin
        idx = IW'(cnt - CW'(1));
      end
    end
  end

  assign out_valid = valid_s[NUM_STAGES];
  assign out_data  = thermo;
  assign out_idx   = idx;
  assign out_count = cnt;
  assign out_zero  = valid_s[NUM_STAGES] && (cnt == '0);
  assign out_tag   = tag_s[NUM_STAGES];

endmodule

// File: tb/tb_thermo_scan_pipe.sv
// Directed bench for thermo_scan_pipe at WIDTH=8, NUM_STAGES=3, TAG_W=4:
// fixed vectors, stall/ordering, a random stream against a reference, and reset.
module tb_thermo_scan_pipe;

  localparam int W  = 8;
  localparam int NS = 3;
  localparam int TW = 4;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [2:0]    out_idx;
  logic [3:0]    out_count;
  logic          out_zero;
  logic [TW-1:0] out_tag;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]  data;
    logic [2:0]    idx;
    logic [3:0]    count;
    logic          zero;
    logic [TW-1:0] tag;
  } exp_t;

  exp_t exp_q[$];

  thermo_scan_pipe #(.WIDTH(W), .NUM_STAGES(NS), .TAG_W(TW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_count (out_count),
    .out_zero  (out_zero),
    .out_tag   (out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Straight-line reference: running OR from the fill end.
  function automatic exp_t ref_model(input logic [W-1:0] d, input logic up, input logic [TW-1:0] t);
    exp_t e;
    logic acc;
    acc    = 1'b0;
    e.data = '0;
    e.idx  = '0;
    if (!up) begin
      for (int i = W - 1; i >= 0; i--) begin
        acc = acc | d[i];
        e.data[i] = acc;
      end
      for (int i = 0; i < W; i++) if (d[i]) e.idx = 3'(i);
    end else begin
      for (int i = 0; i < W; i++) begin
        acc = acc | d[i];
        e.data[i] = acc;
      end
      for (int i = W - 1; i >= 0; i--) if (d[i]) e.idx = 3'(i);
    end
    e.count = 4'($countones(e.data));
    e.zero  = (d == '0);
    e.tag   = t;
    return e;
  endfunction

  task automatic check_outputs(input string name, input exp_t e);
    check({name, " data"},  32'(out_data),  32'(e.data));
    check({name, " idx"},   32'(out_idx),   32'(e.idx));
    check({name, " count"}, 32'(out_count), 32'(e.count));
    check({name, " zero"},  32'(out_zero),  32'(e.zero));
    check({name, " tag"},   32'(out_tag),   32'(e.tag));
  endtask

  task automatic check_idle(input string name);
    check({name, " valid"}, 32'(out_valid), 32'd0);
    check({name, " data"},  32'(out_data),  32'd0);
    check({name, " idx"},   32'(out_idx),   32'd0);
    check({name, " count"}, 32'(out_count), 32'd0);
    check({name, " zero"},  32'(out_zero),  32'd0);
    check({name, " tag"},   32'(out_tag),   32'd0);
  endtask

  // One transaction with out_ready=1; checks the 3-cycle latency and the result.
  task automatic send_one(input string name, input logic [W-1:0] d, input logic up,
                          input logic [TW-1:0] t, input exp_t e);
    int lat;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = up;
    in_tag   = t;
    check({name, " in_ready"}, 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      step();
      lat++;
    end
    check({name, " latency"}, 32'(lat), 32'd3);
    check_outputs(name, e);
    step();
    check({name, " drained"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    exp_t got;
    logic [W-1:0] d;
    logic up;
    logic [TW-1:0] t;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b1;
    #2;
    check_idle("reset");
    check("reset in_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Hand-computed directed vectors.
    e = '{data: 8'b0011_1111, idx: 3'd5, count: 4'd6, zero: 1'b0, tag: 4'd5};
    send_one("down_24", 8'b0010_0100, 1'b0, 4'd5, e);
    e = '{data: 8'b1111_1100, idx: 3'd2, count: 4'd6, zero: 1'b0, tag: 4'd6};
    send_one("up_24", 8'b0010_0100, 1'b1, 4'd6, e);
    e = '{data: 8'h80, idx: 3'd7, count: 4'd1, zero: 1'b0, tag: 4'd7};
    send_one("up_80", 8'h80, 1'b1, 4'd7, e);
    e = '{data: 8'h00, idx: 3'd0, count: 4'd0, zero: 1'b1, tag: 4'd8};
    send_one("down_zero", 8'h00, 1'b0, 4'd8, e);
    e = '{data: 8'h00, idx: 3'd0, count: 4'd0, zero: 1'b1, tag: 4'd9};
    send_one("up_zero", 8'h00, 1'b1, 4'd9, e);
    e = '{data: 8'h01, idx: 3'd0, count: 4'd1, zero: 1'b0, tag: 4'd10};
    send_one("down_01", 8'h01, 1'b0, 4'd10, e);
    e = '{data: 8'hFF, idx: 3'd0, count: 4'd8, zero: 1'b0, tag: 4'd11};
    send_one("up_01", 8'h01, 1'b1, 4'd11, e);

    // Stall: fill the three stages with tags 1..3, tag 4 waits at the input.
    out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1'b1;
      in_data  = 8'h01 << k;
      in_mode  = 1'b0;
      in_tag   = 4'(k);
      check("stall accept in_ready", 32'(in_ready), 32'd1);
      step();
    end
    in_data = 8'h10;
    in_tag  = 4'd4;
    check("stall full in_ready", 32'(in_ready), 32'd0);
    check("stall out_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      check("stall hold in_ready", 32'(in_ready), 32'd0);
      check("stall hold valid", 32'(out_valid), 32'd1);
      check_outputs("stall hold", '{data: 8'h03, idx: 3'd1, count: 4'd2, zero: 1'b0, tag: 4'd1});
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    check("release t2 valid", 32'(out_valid), 32'd1);
    check_outputs("release t2", '{data: 8'h07, idx: 3'd2, count: 4'd3, zero: 1'b0, tag: 4'd2});
    step();
    check("release t3 valid", 32'(out_valid), 32'd1);
    check_outputs("release t3", '{data: 8'h0F, idx: 3'd3, count: 4'd4, zero: 1'b0, tag: 4'd3});
    step();
    check("release t4 valid", 32'(out_valid), 32'd1);
    check_outputs("release t4", '{data: 8'h1F, idx: 3'd4, count: 4'd5, zero: 1'b0, tag: 4'd4});
    step();
    check("release empty", 32'(out_valid), 32'd0);

    // Streaming: 64 back-to-back vectors, one result per cycle after 3 cycles.
    for (int cyc = 0; cyc <= 67; cyc++) begin
      check("stream valid", 32'(out_valid), 32'((cyc >= 3) && (cyc <= 66)));
      if (out_valid && exp_q.size() > 0) begin
        got = exp_q.pop_front();
        check_outputs("stream", got);
      end
      if (cyc < 64) begin
        d  = 8'($urandom);
        if (cyc % 8 == 0) d = 8'h00;
        up = 1'($urandom);
        t  = 4'($urandom);
        in_valid = 1'b1;
        in_data  = d;
        in_mode  = up;
        in_tag   = t;
        check("stream in_ready", 32'(in_ready), 32'd1);
        exp_q.push_back(ref_model(d, up, t));
      end else begin
        in_valid = 1'b0;
      end
      step();
    end
    check("stream queue drained", 32'(exp_q.size()), 32'd0);

    // Reset with two transactions in flight.
    in_valid = 1'b1;
    in_data  = 8'h22;
    in_mode  = 1'b0;
    in_tag   = 4'd12;
    step();
    in_data  = 8'h44;
    in_tag   = 4'd13;
    step();
    in_valid = 1'b0;
    step();
    check("pre-reset valid", 32'(out_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle("async reset");
    step();
    step();
    #3;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("post-reset no stale", 32'(out_valid), 32'd0);
    end
    e = '{data: 8'hF0, idx: 3'd4, count: 4'd4, zero: 1'b0, tag: 4'd9};
    send_one("post-reset", 8'h10, 1'b1, 4'd9, e);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/thermo_scan_pipe.md
Name: thermo_scan_pipe

Overview:
- Pipelined, parametrised thermometer scanner: converts a one-hot or arbitrary vector into a thermometer code via a log-depth prefix-OR network.
- Generalises the combinational UIntToThermo in CommonUtils with configurable width, register-stage count, per-transaction fill direction, leading-one index/count outputs, a sideband tag and valid/ready backpressure.
- Used by arbiters, credit/occupancy masks and free-list scanners that cannot close timing with a single-cycle 32+-bit scan.

Parameters:
- WIDTH, 32, data width; power of two, 2..256.
- NUM_STAGES, 2, register stages; 1..$clog2(WIDTH). Stage k performs prefix-OR levels [k*LPS, min((k+1)*LPS, L)), with L = $clog2(WIDTH) and LPS = ceil(L/NUM_STAGES).
- TAG_W, 4, sideband tag width; must be >= 1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  pipeline can accept input
- in_data  in  WIDTH  vector to scan
- in_mode  in  1  thermo_mode_e: 0 = FILL_DOWN, 1 = FILL_UP
- in_tag  in  TAG_W  opaque sideband, returned unchanged
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_data  out  WIDTH  thermometer result
- out_idx  out  $clog2(WIDTH)  FILL_DOWN: index of highest set input bit; FILL_UP: index of lowest set input bit
- out_count  out  $clog2(WIDTH)+1  number of ones in out_data
- out_zero  out  1  input vector was all zero
- out_tag  out  TAG_W  in_tag of this transaction

Behaviour:
- Reset: every stage valid cleared; out_valid=0, out_data=0, out_idx=0, out_count=0, out_zero=0, out_tag=0. Async assert; synchronous deassert is handled upstream.
- Reset mid-operation discards all in-flight transactions; no partial result is emitted.
- FILL_DOWN: out_data[i]=1 iff some in_data[j]=1 with j>=i, matching UIntToThermo.
- FILL_UP: out_data[i]=1 iff some in_data[j]=1 with j<=i. Implemented by bit-reversing data at pipe entry and reversing again at exit. mode travels with data.
- Index/count: FILL_DOWN gives count=idx+1; FILL_UP gives count=WIDTH-idx. For zero input: out_data=0, idx=0, count=0, out_zero=1.
  - idx is derived from the final thermo vector as popcount-1 (down) or WIDTH-popcount (up), computed in the last stage.
- Handshake: a transfer occurs when valid&&ready on the same edge. Each stage register loads when it is empty or its content moves downstream on the same edge (bubble-collapsing).
- in_ready = !stage0_valid || stage0_advances. This is combinational from out_ready through the stage chain; no other comb path runs input to output.
- Latency: NUM_STAGES cycles from the input transfer to out_valid with no stall. Throughput is 1 per cycle.
- Stall: while out_valid && !out_ready, all out_* hold stable. Capacity is NUM_STAGES transactions. in_ready falls only once all stages are full.
- Order is strictly FIFO. There is no reordering, merging or dropping.
- Simultaneous input and output transfer when full: accepted. Occupancy stays constant.
- Width rules: all internal vectors are WIDTH bits. Out-of-range prefix indices (j<0) never occur, because levels only OR the block boundary bit.

Decomposition:
- Add to CommonUtils:
  - enum thermo_mode_e {THERMO_FILL_DOWN, THERMO_FILL_UP}
  - function ThermoLevelsPerStage(width, stages)
  - function BitReverse, parametrised by width via a localparam max plus mask
- Sub-module thermo_scan_stage (params WIDTH, FIRST_LVL, LAST_LVL, TAG_W):
  - one registered stage containing the combinational prefix-OR levels, valid/ready logic and payload (data, mode, tag) register.
  - The top level instantiates NUM_STAGES of them via generate and adds the entry reversal and the final-stage idx/count/zero.

Test Plan:
- WIDTH=8, NUM_STAGES=3, in_data=8'b0010_0100, mode=DOWN, tag=5 -> 3 cycles later out_data=8'b0011_1111, idx=5, count=6, zero=0, tag=5.
- Same data, mode=UP -> out_data=8'b1111_1100, idx=2, count=6. Then in_data=8'h80, mode=UP -> 8'h80, idx=7, count=1.
- in_data=0 (each mode) -> out_data=0, idx=0, count=0, zero=1. in_data=8'h01, mode=DOWN -> 8'h01, idx=0, count=1, zero=0.
- Hold out_ready=0 and push tags 1,2,3,4 back-to-back -> in_ready=0 after 3 accepts, tag 4 held. On release, tags emerge 1,2,3,4 on consecutive cycles with stable outputs during the stall.
- Continuous valid with out_ready=1, 64 random vectors, both modes -> one result per cycle, latency 3, all matching a reference model of UIntToThermo (reversed for UP).
- Assert rst_n=0 with 2 transactions in flight -> all outputs zero immediately and asynchronously. After release, no stale result appears and the next input returns after 3 cycles.
